// File: rtl/pc_update_unit.sv
// Program-counter register stage for the multicycle MIPS datapath: next-PC select, EPC, sticky
// misaligned-target fault and branch-taken pulse. Optional branch statistics under PC_BRANCH_STATS_EN.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        CondFio,
  input  logic [1:0]  PCSource,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUOut,
  input  logic [25:0] InstrIndex,
  input  logic        EPCWrite,
  input  logic        ClearFault,
  output logic [31:0] PC,
  output logic [31:0] EPC,
  output logic        BranchTaken,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0] BranchCount,
  output logic [15:0] TakenCount,
`endif
  output logic        MisalignFault
);

  logic        pc_en_s;
  logic        taken_s;
  logic        misalign_s;
  logic [31:0] next_pc_s;
  logic [31:0] pc_r;
  logic [31:0] epc_r;
  logic        branch_taken_r;
  logic        fault_r;

  // Write enable, next-PC mux and misalignment detection.
  always_comb begin
    taken_s = PCWriteCond & CondFio;
    pc_en_s = PCWrite | taken_s;
    case (PCSource)
      2'b00:   next_pc_s = ALUResult;
      2'b01:   next_pc_s = ALUOut;
      2'b10:   next_pc_s = {pc_r[31:28], InstrIndex, 2'b00};
      2'b11:   next_pc_s = EXC_VECTOR;
      default: next_pc_s = EXC_VECTOR;
    endcase
    // The exception vector is trusted even if someone parameterises it unaligned.
    if (pc_en_s && (next_pc_s[1:0] != 2'b00) && (PCSource != 2'b11)) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
  end

  // PC, EPC, fault flag and branch-taken pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r           <= RESET_PC;
      epc_r          <= 32'h0000_0000;
      branch_taken_r <= 1'b0;
      fault_r        <= 1'b0;
    end else begin
      branch_taken_r <= taken_s;
      if (misalign_s) begin
        pc_r    <= EXC_VECTOR;
        epc_r   <= pc_r;
        fault_r <= 1'b1;
      end else begin
        if (pc_en_s) begin
          pc_r <= next_pc_s;
        end else begin
          pc_r <= pc_r;
        end
        if (EPCWrite) begin
          epc_r <= ALUResult;
        end else begin
          epc_r <= epc_r;
        end
        if (ClearFault) begin
          fault_r <= 1'b0;
        end else begin
          fault_r <= fault_r;
        end
      end
    end
  end

  assign PC            = pc_r;
  assign EPC           = epc_r;
  assign BranchTaken   = branch_taken_r;
  assign MisalignFault = fault_r;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] branch_cnt_r;
  logic [15:0] taken_cnt_r;

  // Saturating branch statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      branch_cnt_r <= 16'h0000;
      taken_cnt_r  <= 16'h0000;
    end else begin
      if (PCWriteCond && (branch_cnt_r != 16'hFFFF)) begin
        branch_cnt_r <= branch_cnt_r + 16'd1;
      end else begin
        branch_cnt_r <= branch_cnt_r;
      end
      if (taken_s && (taken_cnt_r != 16'hFFFF)) begin
        taken_cnt_r <= taken_cnt_r + 16'd1;
      end else begin
        taken_cnt_r <= taken_cnt_r;
      end
    end
  end

  assign BranchCount = branch_cnt_r;
  assign TakenCount  = taken_cnt_r;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed vector table, randomized run against a
// behavioural model, and counter checks when PC_BRANCH_STATS_EN is defined.
module tb_pc_update_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, CondFio, EPCWrite, ClearFault;
  logic [1:0]  PCSource;
  logic [31:0] ALUResult, ALUOut;
  logic [25:0] InstrIndex;
  logic [31:0] PC, EPC;
  logic        BranchTaken, MisalignFault;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] BranchCount, TakenCount;
`endif

  int n_vec = 0;
  int n_err = 0;

  pc_update_unit dut (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .CondFio(CondFio), .PCSource(PCSource), .ALUResult(ALUResult), .ALUOut(ALUOut),
    .InstrIndex(InstrIndex), .EPCWrite(EPCWrite), .ClearFault(ClearFault),
    .PC(PC), .EPC(EPC), .BranchTaken(BranchTaken),
`ifdef PC_BRANCH_STATS_EN
    .BranchCount(BranchCount), .TakenCount(TakenCount),
`endif
    .MisalignFault(MisalignFault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, pcw, pcwc, cond, epcw, clr;
    logic [1:0]  src;
    logic [31:0] alur, aluo;
    logic [25:0] idx;
    logic [31:0] e_pc, e_epc;
    logic        e_bt, e_mf;
  } vec_t;

  function automatic vec_t mk(logic rst, logic pcw, logic pcwc, logic cond, logic [1:0] src,
                              logic [31:0] alur, logic [31:0] aluo, logic [25:0] idx,
                              logic epcw, logic clr, logic [31:0] e_pc, logic [31:0] e_epc,
                              logic e_bt, logic e_mf);
    vec_t v;
    v.rst = rst; v.pcw = pcw; v.pcwc = pcwc; v.cond = cond; v.src = src;
    v.alur = alur; v.aluo = aluo; v.idx = idx; v.epcw = epcw; v.clr = clr;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_bt = e_bt; v.e_mf = e_mf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic pcw, input logic pcwc, input logic cond,
                       input logic [1:0] src, input logic [31:0] alur, input logic [31:0] aluo,
                       input logic [25:0] idx, input logic epcw, input logic clr);
    reset = rst; PCWrite = pcw; PCWriteCond = pcwc; CondFio = cond; PCSource = src;
    ALUResult = alur; ALUOut = aluo; InstrIndex = idx; EPCWrite = epcw; ClearFault = clr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[21];

  // Reference model state
  logic [31:0] m_pc, m_epc, m_tgt, m_old;
  logic        m_bt, m_mf, m_taken, m_wr;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);

    //          rst  pcw  pcwc cond src    ALUResult     ALUOut        idx          epcw clr   PC            EPC           bt   mf
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,2'b00,32'h0000_0000,32'h0000_0000,26'h0000000,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0);
    tbl[1]  = mk(1'b0,1'b1,1'b0,1'b0,2'b00,32'h0000_0004,32'h0000_0000,26'h0000000,1'b0,1'b0,32'h0000_0004,32'h0000_0000,1'b0,1'b0);
    tbl[2]  = mk(1'b0,1'b0,1'b1,1'b1,2'b01,32'h0000_0000,32'h0000_0040,26'h0000000,1'b0,1'b0,32'h0000_0040,32'h0000_0000,1'b1,1'b0);
    tbl[3]  = mk(1'b0,1'b0,1'b0,1'b0,2'b01,32'h0000_0000,32'h0000_0040,26'h0000000,1'b0,1'b0,32'h0000_0040,32'h0000_0000,1'b0,1'b0);
    tbl[4]  = mk(1'b0,1'b0,1'b1,1'b0,2'b01,32'h0000_0000,32'h0000_0088,26'h0000000,1'b0,1'b0,32'h0000_0040,32'h0000_0000,1'b0,1'b0);
    tbl[5]  = mk(1'b0,1'b1,1'b0,1'b0,2'b00,32'hA000_0010,32'h0000_0000,26'h0000000,1'b0,1'b0,32'hA000_0010,32'h0000_0000,1'b0,1'b0);
    tbl[6]  = mk(1'b0,1'b1,1'b0,1'b0,2'b10,32'h0000_0000,32'h0000_0000,26'h0000123,1'b0,1'b0,32'hA000_048C,32'h0000_0000,1'b0,1'b0);
    tbl[7]  = mk(1'b0,1'b1,1'b0,1'b0,2'b00,32'h0000_0100,32'h0000_0000,26'h0000000,1'b0,1'b0,32'h0000_0100,32'h0000_0000,1'b0,1'b0);
    tbl[8]  = mk(1'b0,1'b1,1'b0,1'b0,2'b01,32'h0000_0555,32'h0000_0042,26'h0000000,1'b1,1'b0,32'h0000_0080,32'h0000_0100,1'b0,1'b1);
    tbl[9]  = mk(1'b0,1'b0,1'b0,1'b0,2'b00,32'h0000_0000,32'h0000_0000,26'h0000000,1'b0,1'b0,32'h0000_0080,32'h0000_0100,1'b0,1'b1);
    tbl[10] = mk(1'b0,1'b0,1'b0,1'b0,2'b00,32'h0000_0000,32'h0000_0000,26'h0000000,1'b0,1'b1,32'h0000_0080,32'h0000_0100,1'b0,1'b0);
    tbl[11] = mk(1'b0,1'b1,1'b0,1'b0,2'b00,32'h0000_0202,32'h0000_0000,26'h0000000,1'b0,1'b1,32'h0000_0080,32'h0000_0080,1'b0,1'b1);
    tbl[12] = mk(1'b0,1'b0,1'b0,1'b0,2'b00,32'h0000_0000,32'h0000_0000,26'h0000000,1'b0,1'b1,32'h0000_0080,32'h0000_0080,1'b0,1'b0);
    tbl[13] = mk(1'b0,1'b1,1'b0,1'b0,2'b11,32'h0000_0FFC,32'h0000_0000,26'h0000000,1'b1,1'b0,32'h0000_0080,32'h0000_0FFC,1'b0,1'b0);
    tbl[14] = mk(1'b0,1'b1,1'b0,1'b0,2'b00,32'hFFFF_FFF0,32'h0000_0000,26'h0000000,1'b0,1'b0,32'hFFFF_FFF0,32'h0000_0FFC,1'b0,1'b0);
    tbl[15] = mk(1'b0,1'b1,1'b0,1'b0,2'b10,32'h0000_0000,32'h0000_0000,26'h3FFFFFF,1'b0,1'b0,32'hFFFF_FFFC,32'h0000_0FFC,1'b0,1'b0);
    tbl[16] = mk(1'b0,1'b1,1'b1,1'b0,2'b00,32'h0000_0008,32'h0000_0000,26'h0000000,1'b0,1'b0,32'h0000_0008,32'h0000_0FFC,1'b0,1'b0);
    tbl[17] = mk(1'b0,1'b1,1'b1,1'b1,2'b00,32'h0000_000C,32'h0000_0000,26'h0000000,1'b0,1'b0,32'h0000_000C,32'h0000_0FFC,1'b1,1'b0);
    tbl[18] = mk(1'b1,1'b1,1'b1,1'b1,2'b00,32'h0000_0003,32'h0000_0000,26'h0000000,1'b1,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0);
    tbl[19] = mk(1'b0,1'b0,1'b0,1'b0,2'b00,32'h0000_1234,32'h0000_0000,26'h0000000,1'b1,1'b0,32'h0000_0000,32'h0000_1234,1'b0,1'b0);
    tbl[20] = mk(1'b0,1'b0,1'b1,1'b1,2'b01,32'h0000_0000,32'h0000_0041,26'h0000000,1'b0,1'b0,32'h0000_0080,32'h0000_0000,1'b1,1'b1);

    step();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].pcw, tbl[i].pcwc, tbl[i].cond, tbl[i].src,
            tbl[i].alur, tbl[i].aluo, tbl[i].idx, tbl[i].epcw, tbl[i].clr);
      step();
      chk("tbl_pc", i, PC, tbl[i].e_pc);
      chk("tbl_epc", i, EPC, tbl[i].e_epc);
      chk("tbl_bt", i, {31'd0, BranchTaken}, {31'd0, tbl[i].e_bt});
      chk("tbl_fault", i, {31'd0, MisalignFault}, {31'd0, tbl[i].e_mf});
    end

    // BranchTaken must drop the cycle after a taken branch
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 26'h0, 1'b0, 1'b1);
    step();
    chk("bt_pulse_end", 0, {31'd0, BranchTaken}, 32'd0);

    // Randomized run against the behavioural model
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
    step();
    m_pc = 32'h0000_0000; m_epc = 32'h0000_0000; m_bt = 1'b0; m_mf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC),
            $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC),
            26'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if (reset) begin
        m_pc = 32'h0000_0000; m_epc = 32'h0000_0000; m_bt = 1'b0; m_mf = 1'b0;
      end else begin
        m_taken = PCWriteCond && CondFio;
        m_wr    = PCWrite || m_taken;
        m_old   = m_pc;
        if (PCSource == 2'd0)      m_tgt = ALUResult;
        else if (PCSource == 2'd1) m_tgt = ALUOut;
        else if (PCSource == 2'd2) m_tgt = (m_old / 32'h1000_0000) * 32'h1000_0000 + {6'd0, InstrIndex} * 32'd4;
        else                       m_tgt = 32'h0000_0080;
        m_bt = m_taken;
        if (m_wr && (m_tgt % 32'd4 != 32'd0) && PCSource != 2'd3) begin
          m_pc = 32'h0000_0080; m_epc = m_old; m_mf = 1'b1;
        end else begin
          if (m_wr) m_pc = m_tgt;
          if (EPCWrite) m_epc = ALUResult;
          if (ClearFault) m_mf = 1'b0;
        end
      end
      step();
      chk("rnd_pc", i, PC, m_pc);
      chk("rnd_epc", i, EPC, m_epc);
      chk("rnd_bt", i, {31'd0, BranchTaken}, {31'd0, m_bt});
      chk("rnd_fault", i, {31'd0, MisalignFault}, {31'd0, m_mf});
    end

`ifdef PC_BRANCH_STATS_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
    step();
    chk("cnt_reset_b", 0, {16'd0, BranchCount}, 32'd0);
    chk("cnt_reset_t", 0, {16'd0, TakenCount}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, (i % 2 == 0), 2'b01, 32'h0, 32'h0000_0040, 26'h0, 1'b0, 1'b0);
      step();
    end
    chk("cnt_branch", 0, {16'd0, BranchCount}, 32'd5);
    chk("cnt_taken", 0, {16'd0, TakenCount}, 32'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0, 32'h0000_0040, 26'h0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step();
    chk("cnt_sat_branch", 0, {16'd0, BranchCount}, 32'h0000_FFFF);
    chk("cnt_sat_taken", 0, {16'd0, TakenCount}, 32'h0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
